// File: rtl/led_display_pkg.sv
// -----------------------------------------------------------------------------
// led_display_pkg
//   Shared geometry and types for the HUB75 panel driver.
//   GL_NUM_COL_PIXELS : pixels per panel row (one shift per column)
//   rgb_row_t         : one display row, top and bottom halves, each with
//                       red/green/blue bit vectors indexed by column
//   GL_RGB_ROW_W      : flat width of rgb_row_t for port declarations
//   hub75_state_t     : driver FSM states
//   shift_row()       : moves every colour vector one column towards the MSB
// -----------------------------------------------------------------------------
package led_display_pkg;

    localparam int GL_NUM_COL_PIXELS = 64;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        SHOW
    } hub75_state_t;

    // The MSB of each vector is the column currently on the pins, so a left
    // shift presents the next lower column.
    function automatic rgb_row_t shift_row(input rgb_row_t r);
        rgb_row_t s;
        s.top.red   = r.top.red   << 1;
        s.top.green = r.top.green << 1;
        s.top.blue  = r.top.blue  << 1;
        s.bot.red   = r.bot.red   << 1;
        s.bot.green = r.bot.green << 1;
        s.bot.blue  = r.bot.blue  << 1;
        return s;
    endfunction

endpackage

// File: rtl/led_display_shift_clk_gen.sv
// -----------------------------------------------------------------------------
// led_display_shift_clk_gen
//   Generates the panel shift clock for one row of NUM_COLS columns.
//   Each column is SHIFT_CLK_DIV cycles low followed by SHIFT_CLK_DIV cycles
//   high. While enable_in is low the generator sits parked (sclk low, first
//   column), so a row always starts from a clean low phase.
//
//   clk_in      : system clock
//   reset_in    : synchronous, active-high reset
//   enable_in   : high for the whole shift phase of a row
//   sclk_out    : registered shift clock level
//   advance_out : one-cycle pulse on a falling sclk edge that has more
//                 columns after it (the data source steps to the next column)
//   done_out    : one-cycle pulse on the falling sclk edge of the last column
// -----------------------------------------------------------------------------
module led_display_shift_clk_gen #(
    parameter int SHIFT_CLK_DIV = 4,
    parameter int NUM_COLS      = 64
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic enable_in,
    output logic sclk_out,
    output logic advance_out,
    output logic done_out
);

    localparam int DIV_W = $clog2(SHIFT_CLK_DIV + 1);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_CLK_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             sclk_q, sclk_d;
    logic             half_end;
    logic             fall;

    // NOTE: every signal written here gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        half_end    = enable_in && (div_q == DIV_LAST);
        fall        = half_end && sclk_q;
        advance_out = fall && (col_q != '0);
        done_out    = fall && (col_q == '0);

        div_d  = div_q;
        sclk_d = sclk_q;
        col_d  = col_q;

        if (!enable_in) begin
            div_d  = '0;
            sclk_d = 1'b0;
            col_d  = COL_LAST;
        end else if (half_end) begin
            div_d  = '0;
            sclk_d = !sclk_q;
            // The column counter parks at 0 after the last column.
            if (advance_out) begin
                col_d = col_q - 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            col_q  <= COL_LAST;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            col_q  <= col_d;
        end
    end

    assign sclk_out = sclk_q;

endmodule

// File: rtl/led_display_hub75_driver.sv
// -----------------------------------------------------------------------------
// led_display_hub75_driver
//   Takes one row of pixels per valid/ready handshake and drives it onto a
//   HUB75 panel: shift all columns, blank, switch address, latch, then light
//   the row for the on-time. The previously latched row stays lit while the
//   next one is being shifted in.
//
//   Optional build macro LED_DISPLAY_BRIGHTNESS_EN adds brightness_in, which
//   scales the lit time to ((brightness_in + 1) * on-time) >> 4, minimum 1.
//
//   clk_in          : system clock
//   reset_in        : synchronous, active-high reset; blanks the panel
//   row_in          : rgb_row_t, column c of each vector is pixel c
//   row_valid_in    : row_in / row_address_in valid
//   row_ready_out   : driver idle and able to take a row (registered)
//   row_address_in  : panel row address for row_in
//   brightness_in   : (LED_DISPLAY_BRIGHTNESS_EN only) 0..15 lit-time scale
//   r1/g1/b1_out    : top-half colour data
//   r2/g2/b2_out    : bottom-half colour data
//   sclk_out        : panel shift clock, data sampled on its rising edge
//   latch_out       : panel latch strobe
//   oe_n_out        : panel output enable, active low
//   addr_out        : panel row address A..D
// -----------------------------------------------------------------------------
module led_display_hub75_driver
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ  = 100_000_000,
    parameter int SIMULATION    = 0,
    parameter int SHIFT_CLK_DIV = 4,
    parameter int LATCH_CYCLES  = 2,
    parameter int ON_CYCLES     = 20_000
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [GL_RGB_ROW_W-1:0] row_in,
    input  logic                    row_valid_in,
    output logic                    row_ready_out,
    input  logic [3:0]              row_address_in,
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    input  logic [3:0]              brightness_in,
`endif
    output logic                    r1_out,
    output logic                    g1_out,
    output logic                    b1_out,
    output logic                    r2_out,
    output logic                    g2_out,
    output logic                    b2_out,
    output logic                    sclk_out,
    output logic                    latch_out,
    output logic                    oe_n_out,
    output logic [3:0]              addr_out
);

    localparam int          ON_LEN     = (SIMULATION != 0) ? 100 : ON_CYCLES;
    localparam logic [19:0] LATCH_LAST = 20'(LATCH_CYCLES - 1);

    if (SYS_CLK_FREQ < 1) begin : g_bad_freq
        $error("SYS_CLK_FREQ must be positive");
    end
    if (SHIFT_CLK_DIV < 1 || SHIFT_CLK_DIV > 255) begin : g_bad_div
        $error("SHIFT_CLK_DIV must be 1..255");
    end
    if (LATCH_CYCLES < 1 || LATCH_CYCLES > 15) begin : g_bad_latch
        $error("LATCH_CYCLES must be 1..15");
    end
    if (ON_LEN < 1 || ON_LEN > 1048575) begin : g_bad_on
        $error("ON_CYCLES must be 1..2^20-1");
    end

    hub75_state_t state_q, state_d;

    rgb_row_t    row_q, row_d;
    logic [3:0]  addr_cap_q, addr_cap_d;
    logic        lit_q, lit_d;
    logic [19:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        latch_q, latch_d;
    logic        oe_n_q, oe_n_d;
    logic [3:0]  addr_q, addr_d;

    logic        accept;
    logic        shift_advance;
    logic        shift_done;
    logic [19:0] show_len;

    assign accept = ready_q && row_valid_in;

    led_display_shift_clk_gen #(
        .SHIFT_CLK_DIV (SHIFT_CLK_DIV),
        .NUM_COLS      (GL_NUM_COL_PIXELS)
    ) u_shift_clk_gen (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .enable_in   (state_q == SHIFT),
        .sclk_out    (sclk_out),
        .advance_out (shift_advance),
        .done_out    (shift_done)
    );

`ifdef LED_DISPLAY_BRIGHTNESS_EN
    logic [19:0] show_len_q, show_len_d;
    logic [19:0] scaled_len;

    always_comb begin
        // (b + 1) * ON_LEN never exceeds 16 * ON_LEN, so the shifted result
        // always fits back into 20 bits.
        scaled_len = 20'(((24'(brightness_in) + 24'd1) * 24'(ON_LEN)) >> 4);
        show_len_d = show_len_q;
        if (accept) begin
            show_len_d = (scaled_len == '0) ? 20'd1 : scaled_len;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            show_len_q <= 20'(ON_LEN);
        end else begin
            show_len_q <= show_len_d;
        end
    end

    assign show_len = show_len_q;
`else
    assign show_len = 20'(ON_LEN);
`endif

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. cnt_q restarts at 0 on entry to LATCH and SHOW.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                         state_d = SHIFT;
            SHIFT:   if (shift_done)                     state_d = BLANK;
            BLANK:                                       state_d = LATCH;
            LATCH:   if (cnt_q >= LATCH_LAST)            state_d = SHOW;
            SHOW:    if (cnt_q >= show_len - 20'd1)      state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    // Row data, address capture, lit flag and phase counter.
    always_comb begin
        row_d      = row_q;
        addr_cap_d = addr_cap_q;
        if (accept) begin
            row_d      = rgb_row_t'(row_in);
            addr_cap_d = row_address_in;
        end else if (shift_advance) begin
            // Steps on the falling sclk edge so data only moves while sclk is low.
            row_d = shift_row(row_q);
        end

        lit_d = lit_q || (state_d == SHOW);

        cnt_d = '0;
        if ((state_d == state_q) && (state_q == LATCH || state_q == SHOW)) begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    // Output logic: panel controls are registered from the next state so they
    // switch cleanly with the state they belong to.
    always_comb begin
        ready_d = (state_d == IDLE);
        latch_d = (state_d == LATCH);
        case (state_d)
            SHOW:        oe_n_d = 1'b0;
            IDLE, SHIFT: oe_n_d = !lit_d;
            default:     oe_n_d = 1'b1;
        endcase
        // The address moves on the edge leaving BLANK: the panel was already
        // dark for the whole BLANK cycle and stays dark through LATCH.
        addr_d = (state_q == BLANK) ? addr_cap_q : addr_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            // NOTE: the row register is reset even though it is wide, because
            // its top column drives the colour pins directly.
            row_q      <= '0;
            addr_cap_q <= '0;
            lit_q      <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            latch_q    <= 1'b0;
            oe_n_q     <= 1'b1;
            addr_q     <= '0;
        end else begin
            row_q      <= row_d;
            addr_cap_q <= addr_cap_d;
            lit_q      <= lit_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            latch_q    <= latch_d;
            oe_n_q     <= oe_n_d;
            addr_q     <= addr_d;
        end
    end

    assign row_ready_out = ready_q;
    assign latch_out     = latch_q;
    assign oe_n_out      = oe_n_q;
    assign addr_out      = addr_q;

    assign r1_out = row_q.top.red[GL_NUM_COL_PIXELS-1];
    assign g1_out = row_q.top.green[GL_NUM_COL_PIXELS-1];
    assign b1_out = row_q.top.blue[GL_NUM_COL_PIXELS-1];
    assign r2_out = row_q.bot.red[GL_NUM_COL_PIXELS-1];
    assign g2_out = row_q.bot.green[GL_NUM_COL_PIXELS-1];
    assign b2_out = row_q.bot.blue[GL_NUM_COL_PIXELS-1];

endmodule

// File: doc/led_display_hub75_driver.md
Name: led_display_hub75_driver

Overview:
- Downstream stage of the row pattern generator.
- Accepts one rgb_row_t plus a 4-bit row address per valid/ready handshake.
- Serialises the row onto a HUB75 panel interface: six colour lines, shift clock, latch, active-low output enable, and address lines.
- Owns all panel timing: shift, blank, latch and display on-time. Upstream only supplies row content and sequencing.

Parameters:
- SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz; documentation/timing only.
- SIMULATION, 0, when nonzero, ON_CYCLES is replaced by 100 for short sims.
- SHIFT_CLK_DIV, 4, system clocks per shift-clock half-period; legal range 1..255.
- LATCH_CYCLES, 2, system clocks latch_out is held high; legal range 1..15.
- ON_CYCLES, 20_000, system clocks of lit time per row after latch; legal range 1..2^20-1.

Ports:
- clk_in  in  1  system clock.
- reset_in  in  1  synchronous, active-high reset.
- row_in  in  GL_RGB_ROW_W  rgb_row_t; top/bot halves, each with red/green/blue vectors of GL_NUM_COL_PIXELS bits.
- row_valid_in  in  1  row_in/row_address_in valid.
- row_ready_out  out  1  driver can accept a row.
- row_address_in  in  4  panel row (top half) for row_in.
- r1_out, g1_out, b1_out  out  1 each  top-half colour data.
- r2_out, g2_out, b2_out  out  1 each  bottom-half colour data.
- sclk_out  out  1  panel shift clock.
- latch_out  out  1  panel latch.
- oe_n_out  out  1  panel output enable, active low.
- addr_out  out  4  panel row address A..D.

Behaviour:
- Reset values: all six colour outputs 0, sclk_out 0, latch_out 0, oe_n_out 1, addr_out 0, row_ready_out 0. FSM goes to IDLE; lit flag clears.
- Reset mid-operation aborts immediately; the panel is blanked on the next edge.
- FSM states: IDLE, SHIFT, BLANK, LATCH, SHOW.
- IDLE:
  - row_ready_out = 1, registered; first high the cycle after reset deasserts.
  - On row_valid_in & row_ready_out: capture row_in and row_address_in into internal registers, go to SHIFT, drop ready the next cycle.
  - row_valid_in while ready is low is ignored; upstream may pulse valid for a single cycle.
- SHIFT:
  - Columns are sent in order c = GL_NUM_COL_PIXELS-1 down to 0.
  - Per column: drive r1=top.red[c], g1=top.green[c], b1=top.blue[c], r2/g2/b2 from bot; hold sclk_out 0 for SHIFT_CLK_DIV cycles, then 1 for SHIFT_CLK_DIV cycles.
  - The panel samples data on the sclk rising edge; data changes only while sclk is low.
  - SHIFT lasts exactly 2*SHIFT_CLK_DIV*GL_NUM_COL_PIXELS cycles. It ends with sclk 0, then goes to BLANK.
  - The previous row stays lit during SHIFT: oe_n_out = !lit.
- BLANK: one cycle. oe_n_out=1, addr_out <= captured address, go to LATCH.
- LATCH: latch_out=1 for LATCH_CYCLES cycles, oe_n_out=1, then go to SHOW.
- SHOW: lit set; oe_n_out=0 for ON_CYCLES cycles (or the brightness-scaled count), then go to IDLE.
- oe_n_out stays 0 in IDLE/SHIFT while lit=1.
- Colour outputs hold their last value outside SHIFT.
- addr_out changes only in BLANK, while oe_n_out=1.
- Counters:
  - Divider width $clog2(SHIFT_CLK_DIV+1).
  - Column counter width $clog2(GL_NUM_COL_PIXELS); counts down and stops at 0 with no wrap.
  - On-time counter 20 bits, compared with >=.
- Minimum row period = accept cycle + SHIFT + 1 + LATCH_CYCLES + on-time.
- Address is not checked; any 4-bit value, including repeats, is legal.

Optional Feature:
- Macro: LED_DISPLAY_BRIGHTNESS_EN.
- Defined:
  - Adds port brightness_in in 4, sampled at handshake acceptance.
  - SHOW length = ((brightness_in+1) * ON_CYCLES) >> 4, minimum 1 cycle.
  - brightness_in=15 gives the full ON_CYCLES.
- Undefined: no port; SHOW length = ON_CYCLES.

Decomposition:
- Package led_display_pkg holds: GL_NUM_COL_PIXELS, GL_RGB_ROW_W, rgb_row_t, and the hub75_state_t enum (IDLE/SHIFT/BLANK/LATCH/SHOW).
- One sub-module, led_display_shift_clk_gen:
  - Inputs: enable.
  - Outputs: sclk level, a one-cycle falling-edge "advance column" pulse, and a "done" pulse.
  - Parameterised by SHIFT_CLK_DIV and column count.

Test Plan (GL_NUM_COL_PIXELS=64, SHIFT_CLK_DIV=2, LATCH_CYCLES=2, SIMULATION=1 so ON_CYCLES=100):
- Reset for 5 cycles, then release -> outputs at reset values during reset; row_ready_out=1 on the first cycle after release; oe_n_out stays 1 until the first SHOW.
- Accept a row with top.red=64'h1, all else 0, address 5:
  - exactly 64 sclk rising edges;
  - r1_out=1 only at the last edge (column 0);
  - SHIFT spans 256 cycles;
  - addr_out=5 changes with oe_n_out=1;
  - latch_out high for 2 cycles;
  - oe_n_out low for 100 cycles, then ready returns.
- Pulse row_valid_in during SHIFT with a different row -> ignored; the next accepted row is only the one presented while ready=1.
- Two back-to-back rows, addresses 3 then 4 -> second row's SHIFT shows oe_n_out=0 (row 3 still lit); addr_out changes 3->4 only while oe_n_out=1.
- Assert reset_in in the middle of SHIFT (column 30) -> next cycle: sclk_out 0, oe_n_out 1, addr_out 0, ready 0; ready 1 one cycle after release.
- With LED_DISPLAY_BRIGHTNESS_EN: brightness_in=0 -> SHOW lasts 6 cycles; brightness_in=7 -> 50; brightness_in=15 -> 100.
